// File: rtl/audio_pkg.sv
// audio_pkg: AES3 framing constants and packer state type shared across the audio path
package audio_pkg;
    localparam int AES3_FRAME_SAMPLES = 192;
    localparam int AES3_AUDIO_WIDTH   = 20;
    typedef enum logic {FILL, HOLD} packer_state_t;
endpackage

// File: rtl/pcm_sample_packer_byte_assembler.sv
// byte_assembler: pops FIFO bytes and shifts them little-endian into one PCM word
module byte_assembler
    import audio_pkg::*;
#(
    parameter int BYTES_PER_SAMPLE = 3
) (
    input  logic                          clk_25mhz,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          fifo_empty,
    input  logic [7:0]                    fifo_dout,
    input  packer_state_t                 state,
    input  logic                          clear,
    output logic                          fifo_rd_en,
    output logic [8*BYTES_PER_SAMPLE-1:0] word,
    output logic                          word_done
);
    localparam int CW = $clog2(BYTES_PER_SAMPLE + 1);
    localparam logic [CW-1:0] FULL = CW'(BYTES_PER_SAMPLE);
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_SAMPLE - 1);
    logic [CW-1:0] req_cnt, rcv_cnt;
    logic pending;
    logic [8*BYTES_PER_SAMPLE-1:0] shreg;
    assign fifo_rd_en = enable & ~fifo_empty & (req_cnt < FULL) & (state == FILL);
    // the final byte counts as done while still on fifo_dout, saving a cycle per sample
    assign word_done = (rcv_cnt == FULL) | (pending & (rcv_cnt == LAST));
    always_comb begin
        word = shreg;
        for (int k = 0; k < BYTES_PER_SAMPLE; k++)
            if (pending && rcv_cnt == CW'(k)) word[8*k +: 8] = fifo_dout;
    end
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt <= '0;
            rcv_cnt <= '0;
            pending <= 1'b0;
            shreg   <= '0;
        end else if (!enable || clear) begin
            req_cnt <= '0;
            rcv_cnt <= '0;
            pending <= 1'b0;
        end else begin
            pending <= fifo_rd_en;
            req_cnt <= req_cnt + CW'(fifo_rd_en);
            if (pending) begin
                shreg   <= word;
                rcv_cnt <= rcv_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcm_sample_packer.sv
// pcm_sample_packer: packs FIFO bytes into tagged AES3 samples on a valid/ready output
module pcm_sample_packer
    import audio_pkg::*;
#(
    parameter int BYTES_PER_SAMPLE = 3,
    parameter int OUT_WIDTH        = AES3_AUDIO_WIDTH,
    parameter int FRAME_SAMPLES    = AES3_FRAME_SAMPLES
) (
    input  logic                 clk_25mhz,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_dout,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic                 sample_channel,
    output logic                 sample_block_start,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 underrun,
    output logic [15:0]          underrun_count
);
    localparam int WW = 8 * BYTES_PER_SAMPLE;
    localparam int FW = $clog2(FRAME_SAMPLES);
    packer_state_t state;
    logic [WW-1:0] word;
    logic word_done, xfer, channel_cnt, starve;
    logic [FW-1:0] frame_cnt;
    logic [OUT_WIDTH-1:0] conv;
    generate
        if (WW >= OUT_WIDTH) begin : g_trunc
            assign conv = word[WW-1 -: OUT_WIDTH];
        end else begin : g_pad
            assign conv = {word, {(OUT_WIDTH - WW){1'b0}}};
        end
    endgenerate
    assign xfer   = enable & word_done & (~sample_valid | sample_ready);
    assign starve = sample_ready & ~sample_valid & enable;
    byte_assembler #(.BYTES_PER_SAMPLE(BYTES_PER_SAMPLE)) u_asm (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .state     (state),
        .clear     (xfer),
        .fifo_rd_en(fifo_rd_en),
        .word      (word),
        .word_done (word_done)
    );
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else state <= (enable & word_done & ~xfer) ? HOLD : FILL;
    end
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n || !enable) begin
            sample_valid       <= 1'b0;
            sample_out         <= '0;
            sample_channel     <= 1'b0;
            sample_block_start <= 1'b0;
            channel_cnt        <= 1'b0;
            frame_cnt          <= '0;
        end else if (xfer) begin
            sample_valid       <= 1'b1;
            sample_out         <= conv;
            sample_channel     <= channel_cnt;
            sample_block_start <= ~channel_cnt & (frame_cnt == '0);
            channel_cnt        <= ~channel_cnt;
            if (channel_cnt)
                frame_cnt <= (frame_cnt == FW'(FRAME_SAMPLES - 1)) ? '0 : frame_cnt + 1'b1;
        end else if (sample_ready) begin
            sample_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            underrun <= starve;
            if (starve && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 1'b1;
        end
    end
endmodule
